multi_mode_ff_bank: RTL and testbench

- Parametrised bank of WIDTH flip-flops. One mode input selects D, T, JK or SR next-state behaviour for all bits.
- Generalises the standalone D/T/JK/SR flops into a single registered block:
  - enable and synchronous clear;
  - per-bit SR-invalid detection with a sticky error flag;
  - a registered change pulse and a saturating change counter.
- Used wherever the design needs a configurable state register with an activity count.

---
 rtl/multi_mode_ff_bank.sv | 113 +++++++++++
 tb/tb_multi_mode_ff_bank.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank
//   Bank of WIDTH flip-flops sharing one next-state function (D, T, JK or SR)
//   that is selected by mode. The bank provides enable, synchronous clear,
//   a sticky SR-invalid error flag, a registered change pulse and a
//   saturating change counter.
//
// Optional feature:
//   FFBANK_PARITY_EN - adds output 'parity', a registered XOR of all q bits.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   mode     in   00 D, 01 T, 10 JK, 11 SR
//   en       in   update enable (q holds when 0)
//   clr      in   synchronous clear of q, counter and error flag (wins over en)
//   a        in   D / T / J / S per bit
//   b        in   K / R per bit (ignored in D and T modes)
//   q        out  register state
//   changed  out  high for one cycle after an enabled edge that changed q
//   chg_cnt  out  saturating count of edges that changed q
//   sr_err   out  sticky flag, set when S=R=1 on an enabled SR-mode edge
//   parity   out  ^q (only when FFBANK_PARITY_EN is defined)

module multi_mode_ff_bank #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic             changed,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             sr_err
`ifdef FFBANK_PARITY_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    mode_e            mode_sel;
    logic [WIDTH-1:0] qn;
    logic             sr_bad;
    logic             q_diff;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        qn     = q;
        sr_bad = 1'b0;
        case (mode_sel)
            MODE_D:  qn = a;
            MODE_T:  qn = q ^ a;
            // JK characteristic: q+ = J & ~q | ~K & q
            MODE_JK: qn = (a & ~q) | (~b & q);
            // SR: set when S&~R, otherwise hold unless reset (S=R=1 also holds)
            MODE_SR: begin
                qn     = (a & ~b) | (q & ~(a ^ b));
                sr_bad = |(a & b);
            end
            default: qn = q;
        endcase
    end

    assign q_diff = (qn != q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q       <= RESET_VAL;
            changed <= 1'b0;
            chg_cnt <= '0;
            sr_err  <= 1'b0;
        end else if (clr) begin
            q       <= RESET_VAL;
            changed <= 1'b0;
            chg_cnt <= '0;
            sr_err  <= 1'b0;
        end else if (en) begin
            q       <= qn;
            changed <= q_diff;
            if (q_diff && (chg_cnt != '1))
                chg_cnt <= chg_cnt + CNT_W'(1);
            if (sr_bad)
                sr_err <= 1'b1;
        end else begin
            changed <= 1'b0;
        end
    end

`ifdef FFBANK_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            parity <= ^RESET_VAL;
        else if (clr)
            parity <= ^RESET_VAL;
        else if (en)
            parity <= ^qn;
    end
`endif

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
module tb_multi_mode_ff_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       en, clr;
    logic [3:0] a, b;
    logic [3:0] q;
    logic       changed;
    logic [7:0] chg_cnt;
    logic       sr_err;

    logic       s_reset;
    logic [1:0] s_mode;
    logic       s_en, s_clr;
    logic [3:0] s_a, s_b;
    logic [3:0] s_q;
    logic       s_changed;
    logic [2:0] s_cnt;
    logic       s_err;

`ifdef FFBANK_PARITY_EN
    logic parity;
    logic s_parity;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_mode_ff_bank #(.WIDTH(4), .CNT_W(8), .RESET_VAL(4'h0)) dut (
        .clk(clk), .reset(reset), .mode(mode), .en(en), .clr(clr),
        .a(a), .b(b), .q(q), .changed(changed), .chg_cnt(chg_cnt),
        .sr_err(sr_err)
`ifdef FFBANK_PARITY_EN
        , .parity(parity)
`endif
    );

    multi_mode_ff_bank #(.WIDTH(4), .CNT_W(3), .RESET_VAL(4'h0)) dut_sat (
        .clk(clk), .reset(s_reset), .mode(s_mode), .en(s_en), .clr(s_clr),
        .a(s_a), .b(s_b), .q(s_q), .changed(s_changed), .chg_cnt(s_cnt),
        .sr_err(s_err)
`ifdef FFBANK_PARITY_EN
        , .parity(s_parity)
`endif
    );

    typedef struct {
        logic [1:0] mode;
        logic       en;
        logic       clr;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic       ch;
        logic [7:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic [3:0] eq, input logic ech,
                            input logic [7:0] ecnt, input logic eerr);
        chk({tag, ".q"},       32'(q),       32'(eq));
        chk({tag, ".changed"}, 32'(changed), 32'(ech));
        chk({tag, ".chg_cnt"}, 32'(chg_cnt), 32'(ecnt));
        chk({tag, ".sr_err"},  32'(sr_err),  32'(eerr));
`ifdef FFBANK_PARITY_EN
        chk({tag, ".parity"},  32'(parity),  32'(^eq));
`endif
    endtask

    initial begin
        //            mode   en    clr   a      b      q      ch    cnt    err
        vecs[0]  = '{2'b00, 1'b1, 1'b0, 4'h5, 4'h0, 4'h5, 1'b1, 8'd1, 1'b0};
        vecs[1]  = '{2'b01, 1'b1, 1'b0, 4'h3, 4'h0, 4'h6, 1'b1, 8'd2, 1'b0};
        vecs[2]  = '{2'b01, 1'b1, 1'b0, 4'h3, 4'h0, 4'h5, 1'b1, 8'd3, 1'b0};
        vecs[3]  = '{2'b01, 1'b1, 1'b0, 4'h0, 4'h0, 4'h5, 1'b0, 8'd3, 1'b0};
        vecs[4]  = '{2'b00, 1'b0, 1'b1, 4'h9, 4'h0, 4'h0, 1'b0, 8'd0, 1'b0};
        vecs[5]  = '{2'b10, 1'b1, 1'b0, 4'hC, 4'hA, 4'hC, 1'b1, 8'd1, 1'b0};
        vecs[6]  = '{2'b10, 1'b1, 1'b0, 4'hC, 4'hA, 4'h4, 1'b1, 8'd2, 1'b0};
        vecs[7]  = '{2'b10, 1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 8'd0, 1'b0};
        vecs[8]  = '{2'b11, 1'b1, 1'b0, 4'h3, 4'h5, 4'h2, 1'b1, 8'd1, 1'b1};
        vecs[9]  = '{2'b11, 1'b1, 1'b0, 4'h0, 4'h0, 4'h2, 1'b0, 8'd1, 1'b1};
        vecs[10] = '{2'b11, 1'b1, 1'b0, 4'h0, 4'h0, 4'h2, 1'b0, 8'd1, 1'b1};
        vecs[11] = '{2'b11, 1'b1, 1'b0, 4'h0, 4'h0, 4'h2, 1'b0, 8'd1, 1'b1};
        vecs[12] = '{2'b11, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 1'b0};
        vecs[13] = '{2'b11, 1'b0, 1'b0, 4'hF, 4'hF, 4'h0, 1'b0, 8'd0, 1'b0};
        vecs[14] = '{2'b00, 1'b1, 1'b0, 4'hA, 4'h0, 4'hA, 1'b1, 8'd1, 1'b0};
        vecs[15] = '{2'b00, 1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 8'd0, 1'b0};
        vecs[16] = '{2'b00, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 1'b0};
        vecs[17] = '{2'b00, 1'b1, 1'b0, 4'h7, 4'h0, 4'h7, 1'b1, 8'd1, 1'b0};
        vecs[18] = '{2'b01, 1'b1, 1'b0, 4'hF, 4'h0, 4'h8, 1'b1, 8'd2, 1'b0};
        vecs[19] = '{2'b00, 1'b0, 1'b0, 4'hF, 4'h0, 4'h8, 1'b0, 8'd2, 1'b0};
        vecs[20] = '{2'b11, 1'b1, 1'b0, 4'h1, 4'h1, 4'h8, 1'b0, 8'd2, 1'b1};
        vecs[21] = '{2'b11, 1'b0, 1'b0, 4'h0, 4'hF, 4'h8, 1'b0, 8'd2, 1'b1};
        vecs[22] = '{2'b00, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 1'b0};

        reset = 1'b0; mode = 2'b00; en = 1'b1; clr = 1'b0; a = 4'hF; b = 4'h0;
        s_reset = 1'b0; s_mode = 2'b01; s_en = 1'b0; s_clr = 1'b0; s_a = 4'h1; s_b = 4'h0;

        // Reset held across two edges with active-looking inputs.
        step();
        step();
        chk_main("reset", 4'h0, 1'b0, 8'd0, 1'b0);
        reset = 1'b1;
        s_reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            mode = vecs[i].mode; en = vecs[i].en; clr = vecs[i].clr;
            a = vecs[i].a; b = vecs[i].b;
            step();
            chk_main($sformatf("vec%0d", i), vecs[i].q, vecs[i].ch, vecs[i].cnt, vecs[i].err);
        end

        // Asynchronous reset mid-cycle after loading q=A.
        mode = 2'b00; en = 1'b1; clr = 1'b0; a = 4'hA;
        step();
        chk_main("pre_async", 4'hA, 1'b1, 8'd1, 1'b0);
        en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_main("async_rst", 4'h0, 1'b0, 8'd0, 1'b0);
        reset = 1'b1;
        step();
        chk_main("post_async", 4'h0, 1'b0, 8'd0, 1'b0);

`ifdef FFBANK_PARITY_EN
        begin
            logic [3:0] pq[4];
            logic       pp[4];
            pq[0] = 4'h0; pq[1] = 4'h5; pq[2] = 4'h7; pq[3] = 4'hF;
            pp[0] = 1'b0; pp[1] = 1'b0; pp[2] = 1'b1; pp[3] = 1'b0;
            mode = 2'b00; en = 1'b1;
            for (int i = 0; i < 4; i++) begin
                a = pq[i];
                step();
                chk($sformatf("par_q%0d", i), 32'(q), 32'(pq[i]));
                chk($sformatf("par%0d", i), 32'(parity), 32'(pp[i]));
            end
        end
`endif

        // Saturating counter on the CNT_W=3 instance: toggle bit0 for 10 edges.
        s_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("sat_cnt%0d", i), 32'(s_cnt), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
            chk($sformatf("sat_q%0d", i), 32'(s_q), (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        s_clr = 1'b1;
        step();
        chk("sat_clr", 32'(s_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
